// File: rtl/spongent_pkg.sv
// Shared constants and FSM encoding for the Spongent sponge-mode controller.
package spongent_pkg;

    localparam int          B        = 264;       // permutation state width
    localparam int          R_BITS   = 8;         // rate width, state[R_BITS-1:0]
    localparam int          ROUNDS   = 140;       // round-unit iterations per permutation
    localparam int          OUT_BITS = 256;       // digest length
    localparam logic [15:0] IV_INIT  = 16'h009E;  // round counter for round 0
    localparam logic [7:0]  PAD_BYTE = 8'h80;     // single-bit pad into the rate
    localparam int          OUT_BYTES = OUT_BITS / R_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_PSTART,
        ST_PWAIT,
        ST_SQUEEZE
    } sponge_state_e;

endpackage : spongent_pkg

// File: rtl/spongent_sponge_ctrl.sv
// Sponge-mode controller: absorbs message bytes into the rate, pads, drives the
// external round unit ROUNDS times per permutation and squeezes the digest.
module spongent_sponge_ctrl #(
    parameter int          B        = spongent_pkg::B,
    parameter int          R_BITS   = spongent_pkg::R_BITS,
    parameter int          ROUNDS   = spongent_pkg::ROUNDS,
    parameter int          OUT_BITS = spongent_pkg::OUT_BITS,
    parameter logic [15:0] IV_INIT  = spongent_pkg::IV_INIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         empty,
    output logic         busy,
    input  logic [7:0]   msg_data,
    input  logic         msg_valid,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic [B-1:0] rnd_state_o,
    output logic [15:0]  rnd_iv_o,
    output logic         rnd_start,
    input  logic [B-1:0] rnd_state_i,
    input  logic [15:0]  rnd_iv_i,
    input  logic         rnd_done,
    output logic [7:0]   out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready
);
    import spongent_pkg::*;

    localparam int         N_OUT      = OUT_BITS / R_BITS;
    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [7:0] LAST_OUT   = 8'(N_OUT - 1);

    // Control and datapath state
    sponge_state_e st_q, st_d;
    logic [B-1:0]  state_q, state_d;
    logic [15:0]   iv_q, iv_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic [7:0]    ocnt_q, ocnt_d;
    logic          pad_pending_q, pad_pending_d;
    logic          pad_done_q, pad_done_d;
    logic          squeezing_q, squeezing_d;
    logic          busy_q, busy_d;

    // Registered outputs
    logic          msg_ready_q, msg_ready_d;
    logic          rnd_start_q, rnd_start_d;
    logic [B-1:0]  rnd_state_q, rnd_state_d;
    logic [15:0]   rnd_iv_q, rnd_iv_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    // Next-state logic: sequencing of absorb, padding, permutation rounds and squeeze
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
        st_d          = st_q;
        state_d       = state_q;
        iv_d          = iv_q;
        rcnt_d        = rcnt_q;
        ocnt_d        = ocnt_q;
        pad_pending_d = pad_pending_q;
        pad_done_d    = pad_done_q;
        squeezing_d   = squeezing_q;
        busy_d        = busy_q;

        unique case (st_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = '0;
                    rcnt_d        = '0;
                    ocnt_d        = '0;
                    pad_pending_d = 1'b0;
                    pad_done_d    = 1'b0;
                    squeezing_d   = 1'b0;
                    busy_d        = 1'b1;
                    if (empty) begin
                        state_d[7:0] = PAD_BYTE;
                        pad_done_d   = 1'b1;
                        st_d         = ST_PSTART;
                    end else begin
                        st_d = ST_ABSORB;
                    end
                end
            end
            ST_ABSORB: begin
                if (msg_valid && msg_ready_q) begin
                    state_d[7:0]  = state_q[7:0] ^ msg_data;
                    pad_pending_d = msg_last;
                    st_d          = ST_PSTART;
                end
            end
            ST_PSTART: begin
                st_d = ST_PWAIT;
            end
            ST_PWAIT: begin
                if (rnd_done) begin
                    state_d = rnd_state_i;
                    iv_d    = rnd_iv_i;
                    if (rcnt_q == LAST_ROUND) begin
                        rcnt_d = '0;
                        if (squeezing_q || pad_done_q) begin
                            squeezing_d = 1'b1;
                            st_d        = ST_SQUEEZE;
                        end else if (pad_pending_q) begin
                            // Padding is a full extra rate block permuted on its own
                            state_d[7:0]  = rnd_state_i[7:0] ^ PAD_BYTE;
                            pad_pending_d = 1'b0;
                            pad_done_d    = 1'b1;
                            st_d          = ST_PSTART;
                        end else begin
                            st_d = ST_ABSORB;
                        end
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                        st_d   = ST_PSTART;
                    end
                end
            end
            ST_SQUEEZE: begin
                if (out_valid_q && out_ready) begin
                    ocnt_d = ocnt_q + 8'd1;
                    if (ocnt_q == LAST_OUT) begin
                        busy_d = 1'b0;
                        st_d   = ST_IDLE;
                    end else begin
                        st_d = ST_PSTART;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        msg_ready_d = (st_d == ST_ABSORB);
        rnd_start_d = (st_d == ST_PSTART);
        rnd_state_d = rnd_state_q;
        rnd_iv_d    = rnd_iv_q;
        if (rnd_start_d) begin
            rnd_state_d = state_d;
            rnd_iv_d    = (rcnt_d == 8'd0) ? IV_INIT : iv_d;
        end
        out_valid_d = (st_d == ST_SQUEEZE);
        out_data_d  = out_data_q;
        if (out_valid_d) begin
            out_data_d = state_d[7:0];
        end
        out_last_d = out_valid_d && (ocnt_d == LAST_OUT);
    end

    // State and output registers; reset aborts any operation immediately
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            st_q          <= ST_IDLE;
            state_q       <= '0;
            iv_q          <= '0;
            rcnt_q        <= '0;
            ocnt_q        <= '0;
            pad_pending_q <= 1'b0;
            pad_done_q    <= 1'b0;
            squeezing_q   <= 1'b0;
            busy_q        <= 1'b0;
            msg_ready_q   <= 1'b0;
            rnd_start_q   <= 1'b0;
            rnd_state_q   <= '0;
            rnd_iv_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
        end else begin
            st_q          <= st_d;
            state_q       <= state_d;
            iv_q          <= iv_d;
            rcnt_q        <= rcnt_d;
            ocnt_q        <= ocnt_d;
            pad_pending_q <= pad_pending_d;
            pad_done_q    <= pad_done_d;
            squeezing_q   <= squeezing_d;
            busy_q        <= busy_d;
            msg_ready_q   <= msg_ready_d;
            rnd_start_q   <= rnd_start_d;
            rnd_state_q   <= rnd_state_d;
            rnd_iv_q      <= rnd_iv_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
        end
    end

    assign busy        = busy_q;
    assign msg_ready   = msg_ready_q;
    assign rnd_start   = rnd_start_q;
    assign rnd_state_o = rnd_state_q;
    assign rnd_iv_o    = rnd_iv_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;

endmodule : spongent_sponge_ctrl

// File: tb/tb_spongent_sponge_ctrl.sv
// Scoreboard bench for spongent_sponge_ctrl with a stub round unit
// (state+1, iv+1, fixed latency), ROUNDS=3 and a two-byte digest.
module tb_spongent_sponge_ctrl;

    localparam int TB_B        = 264;
    localparam int TB_ROUNDS   = 3;
    localparam int TB_OUT_BITS = 16;
    localparam int LAT         = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            empty = 1'b0;
    logic            busy;
    logic [7:0]      msg_data = '0;
    logic            msg_valid = 1'b0;
    logic            msg_last = 1'b0;
    logic            msg_ready;
    logic [TB_B-1:0] rnd_state_o;
    logic [15:0]     rnd_iv_o;
    logic            rnd_start;
    logic [TB_B-1:0] rnd_state_i;
    logic [15:0]     rnd_iv_i;
    logic            rnd_done;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready = 1'b1;

    logic            stub_done;
    logic            stub_busy;
    int              stub_dly;
    logic            spur_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int rs_cnt = 0;
    int mr_cnt = 0;

    logic [23:0] exp_rnd[$];   // {state[7:0], iv}
    logic [8:0]  exp_out[$];   // {last, data}

    spongent_sponge_ctrl #(
        .B        (TB_B),
        .R_BITS   (8),
        .ROUNDS   (TB_ROUNDS),
        .OUT_BITS (TB_OUT_BITS),
        .IV_INIT  (16'h009E)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .empty       (empty),
        .busy        (busy),
        .msg_data    (msg_data),
        .msg_valid   (msg_valid),
        .msg_last    (msg_last),
        .msg_ready   (msg_ready),
        .rnd_state_o (rnd_state_o),
        .rnd_iv_o    (rnd_iv_o),
        .rnd_start   (rnd_start),
        .rnd_state_i (rnd_state_i),
        .rnd_iv_i    (rnd_iv_i),
        .rnd_done    (rnd_done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    assign rnd_done = stub_done | spur_done;

    // Stub round unit: result = input + 1 after LAT cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_state_i <= '0;
            rnd_iv_i    <= '0;
            stub_done   <= 1'b0;
            stub_busy   <= 1'b0;
            stub_dly    <= 0;
        end else begin
            stub_done <= 1'b0;
            if (rnd_start) begin
                rnd_state_i <= rnd_state_o + 1'b1;
                rnd_iv_i    <= rnd_iv_o + 16'd1;
                stub_busy   <= 1'b1;
                stub_dly    <= LAT - 1;
            end else if (stub_busy) begin
                if (stub_dly == 0) begin
                    stub_done <= 1'b1;
                    stub_busy <= 1'b0;
                end else begin
                    stub_dly <= stub_dly - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-request monitor
    always @(negedge clk) begin
        if (!rst && rnd_start) begin
            logic [23:0] e;
            rs_cnt++;
            if (exp_rnd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_unexpected: got state %0h iv %0h with no request expected",
                         rnd_state_o[7:0], rnd_iv_o);
            end else begin
                e = exp_rnd.pop_front();
                check("rnd_state", 64'(rnd_state_o[7:0]), 64'(e[23:16]));
                check("rnd_iv", 64'(rnd_iv_o), 64'(e[15:0]));
            end
        end
        if (!rst && msg_ready) mr_cnt++;
    end

    // Digest monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [8:0] e;
            if (exp_out.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got data %0h last %0b with no byte expected",
                         out_data, out_last);
            end else begin
                e = exp_out.pop_front();
                check("out_data", 64'(out_data), 64'(e[7:0]));
                check("out_last", 64'(out_last), 64'(e[8]));
            end
        end
    end

    task automatic push_perm(input logic [7:0] s0);
        for (int i = 0; i < TB_ROUNDS; i++) begin
            exp_rnd.push_back({8'(s0 + 8'(i)), 16'(16'h009E + 16'(i))});
        end
    endtask

    task automatic push_out(input logic [7:0] d, input logic l);
        exp_out.push_back({l, d});
    endtask

    task automatic do_start(input logic e);
        @(negedge clk);
        start = 1'b1;
        empty = e;
        @(negedge clk);
        start = 1'b0;
        empty = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        while (!msg_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!msg_ready) begin
            checks++;
            errors++;
            $display("FAIL msg_ready_timeout: got ready 0 expected 1");
        end else begin
            msg_valid = 1'b1;
            msg_data  = d;
            msg_last  = l;
            @(negedge clk);
            msg_valid = 1'b0;
            msg_last  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check({name, "_rnd_q"}, 64'(exp_rnd.size()), 64'd0);
        check({name, "_out_q"}, 64'(exp_out.size()), 64'd0);
    endtask

    task automatic outputs_zero(input string name);
        check(name, 64'({busy, msg_ready, rnd_start, |rnd_state_o, |rnd_iv_o,
                         |out_data, out_valid, out_last}), 64'd0);
    endtask

    // Golden single-byte run: 05 -> perm 08 -> pad 88 -> perm 8B (out) -> perm 8E (out, last)
    task automatic push_golden();
        push_perm(8'h05);
        push_perm(8'h88);
        push_out(8'h8B, 1'b0);
        push_perm(8'h8B);
        push_out(8'h8E, 1'b1);
    endtask

    initial begin
        int base;
        int n;
        logic [7:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        outputs_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        outputs_zero("idle_outputs");

        // One-byte message
        base = rs_cnt;
        push_golden();
        do_start(1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        send_byte(8'h05, 1'b1);
        wait_idle("single_byte_done");
        check("single_byte_rnd_starts", 64'(rs_cnt - base), 64'(3 * TB_ROUNDS));

        // Two-byte message: 05 -> 08, ^10 -> 18 -> 1B, pad 9B -> 9E (out) -> A1 (out, last)
        push_perm(8'h05);
        push_perm(8'h18);
        push_perm(8'h9B);
        push_out(8'h9E, 1'b0);
        push_perm(8'h9E);
        push_out(8'hA1, 1'b1);
        do_start(1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h10, 1'b1);
        wait_idle("two_byte_done");

        // Empty message: 80 -> 83 (out) -> 86 (out, last)
        base = mr_cnt;
        n    = rs_cnt;
        push_perm(8'h80);
        push_out(8'h83, 1'b0);
        push_perm(8'h83);
        push_out(8'h86, 1'b1);
        do_start(1'b1);
        wait_idle("empty_done");
        check("empty_no_msg_ready", 64'(mr_cnt - base), 64'd0);
        check("empty_rnd_starts", 64'(rs_cnt - n), 64'(2 * TB_ROUNDS));

        // Back-pressure in SQUEEZE
        push_golden();
        out_ready = 1'b0;
        do_start(1'b0);
        send_byte(8'h05, 1'b1);
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("hold_out_valid_seen", 64'(out_valid), 64'd1);
        held = out_data;
        check("hold_first_byte", 64'(held), 64'h8B);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(held));
            check("hold_no_rnd_start", 64'(rnd_start), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle("hold_done");

        // Reset during PWAIT of the second round, then a fresh run
        push_golden();
        base = rs_cnt;
        do_start(1'b0);
        send_byte(8'h05, 1'b1);
        n = 0;
        while (!(rs_cnt >= base + 2 && !rnd_start) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reset_reached_round2", 64'(rs_cnt - base), 64'd2);
        #1 rst = 1'b1;
        #1 outputs_zero("async_reset_outputs");
        exp_rnd.delete();
        exp_out.delete();
        @(negedge clk);
        outputs_zero("reset_next_edge");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        outputs_zero("after_reset_idle");
        push_golden();
        do_start(1'b0);
        send_byte(8'h05, 1'b1);
        wait_idle("post_reset_done");

        // Spurious rnd_done in ABSORB and start while busy
        push_golden();
        do_start(1'b0);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("spur_still_absorb", 64'(msg_ready), 64'd1);
        check("spur_still_busy", 64'(busy), 64'd1);
        send_byte(8'h05, 1'b1);
        wait_idle("spur_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_spongent_sponge_ctrl

// File: doc/spongent_sponge_ctrl.md
Name: spongent_sponge_ctrl

Overview:
- Sponge-mode controller sitting directly upstream and downstream of the per-round permutation unit.
- Absorbs a byte stream into the rate, appends padding, and runs ROUNDS round-unit iterations per permutation, chaining state and the 16-bit round counter.
- Squeezes the digest as a byte stream.

Parameters:
B, 264, state width in bits.
R_BITS, 8, rate width; rate occupies state[R_BITS-1:0].
ROUNDS, 140, round-unit iterations per permutation (legal range 1..255).
OUT_BITS, 256, digest length; OUT_BITS/R_BITS squeeze outputs.
IV_INIT, 16'h009E, round-counter value for round 0 of every permutation.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begins a new hash.
empty  in  1  sampled with start; 1 means zero-length message.
busy  out  1  high from accepted start until the last digest byte is accepted.
msg_data  in  8  message byte.
msg_valid  in  1  message byte valid.
msg_last  in  1  marks the final message byte.
msg_ready  out  1  controller accepts a byte.
rnd_state_o  out  B  state presented to the round unit.
rnd_iv_o  out  16  round counter presented to the round unit.
rnd_start  out  1  one-cycle request to the round unit.
rnd_state_i  in  B  round result.
rnd_iv_i  in  16  next round-counter value from the round unit.
rnd_done  in  1  one-cycle pulse; rnd_state_i/rnd_iv_i valid.
out_data  out  8  digest byte.
out_valid  out  1  digest byte valid.
out_last  out  1  high with the final digest byte.
out_ready  in  1  sink accepts.

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk.
- Reset values: all outputs 0. Internal state register 0, FSM IDLE, counters 0. Reset mid-operation aborts immediately; no output residue.
- FSM states: IDLE, ABSORB, PSTART, PWAIT, SQUEEZE.
- IDLE:
  - start=1: clear state, busy=1.
  - empty=0 -> ABSORB.
  - empty=1 -> state[7:0]^=8'h80, pad_done=1, -> PSTART.
  - start while busy is ignored.
- ABSORB:
  - msg_ready=1.
  - On msg_valid&&msg_ready: state[7:0]^=msg_data; -> PSTART.
  - If msg_last: set pad_pending.
- Padding:
  - After the permutation that follows the last byte, pad_pending -> pad_done; state[7:0]^=8'h80 and a further permutation is started.
  - Padding is always a full extra rate block.
- PSTART:
  - rnd_start=1 for exactly one cycle.
  - rnd_state_o = state.
  - rnd_iv_o = IV_INIT when rcnt=0, else the latched iv.
  - -> PWAIT.
- PWAIT:
  - On rnd_done: state<=rnd_state_i, iv<=rnd_iv_i.
  - If rcnt==ROUNDS-1: rcnt<=0, permutation done. Otherwise rcnt++ and -> PSTART.
  - rnd_done outside PWAIT is ignored.
  - Round-unit latency is arbitrary; minimum permutation time is ROUNDS*(2+latency) cycles.
- After a permutation completes:
  - Absorbing, no pad yet -> ABSORB.
  - pad_pending -> apply pad, -> PSTART.
  - pad_done, or squeeze in progress -> SQUEEZE.
- SQUEEZE:
  - out_valid=1, out_data=state[7:0].
  - out_last=1 when ocnt==OUT_BITS/R_BITS-1.
  - On out_valid&&out_ready: ocnt++. If last -> IDLE, busy=0. Otherwise -> PSTART (permute between outputs).
  - out_data and out_valid stay stable while out_ready=0.
- One message byte per permutation; msg_ready=0 outside ABSORB.
- Width rules:
  - rcnt is 8 bits; ocnt is 8 bits.
  - IV_INIT is reloaded for every permutation, never carried across permutations.

Decomposition:
- Shared package (spongent_pkg):
  - Constants: B, R_BITS, ROUNDS, OUT_BITS, IV_INIT.
  - PAD_BYTE=8'h80.
  - FSM state encoding.
  - OUT_BYTES=OUT_BITS/R_BITS.
- No sub-module: FSM, counters and the state register live in one file. The round unit is instantiated by the top level, not here.

Test Plan:
- Stub round unit (latency 2, state_o=state_i+1, iv_o=iv_i+1), ROUNDS=3, OUT_BITS=16. start, empty=0, one byte 8'h05 with msg_last:
  - rnd_start pulses 3x per permutation.
  - rnd_iv_o = 9E, 9F, A0 each permutation.
  - 3 permutations total (message, pad, inter-squeeze).
  - 2 digest bytes; out_last on the 2nd.
- empty=1 start:
  - First rnd_state_o[7:0]=8'h80.
  - No msg_ready pulse.
  - Digest appears after 2 permutations total.
- out_ready held 0 for 10 cycles in SQUEEZE: out_data/out_valid stable; no rnd_start issued.
- rst asserted during PWAIT of round 2: all outputs 0 next edge; busy=0; a later start gives a result identical to a fresh run.
- Spurious rnd_done in ABSORB and a start while busy=1: no state change; digest matches the golden run.
- Full-parameter run (B=264, ROUNDS=140, OUT_BITS=256) with the real round unit on message "abc": exactly 32 out_valid handshakes; digest compared against the software model.
